// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned N-bit restoring divider, one quotient bit per clock
// A zero divisor skips the iteration and reports all-ones quotient with the dividend as remainder.
module seq_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_dvd;
    logic [N-1:0]   r_div;
    logic [N:0]     r_rem;
    logic [CW-1:0]  r_cnt;
    logic           r_dbz;

    logic [N:0]     w_shift;
    logic [N:0]     w_diff;
    logic           w_qbit;
    logic [N:0]     w_rem_next;
    logic [N-1:0]   w_quo_next;
    logic           w_last;

    // r_dvd doubles as the quotient register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    assign w_shift    = {r_rem[N-1:0], r_dvd[N-1]};
    assign w_diff     = w_shift - {1'b0, r_div};
    // A set top remainder bit would make the shifted value exceed any divisor.
    assign w_qbit     = r_rem[N] | (w_shift >= {1'b0, r_div});
    assign w_rem_next = w_qbit ? w_diff : w_shift;
    assign w_quo_next = {r_dvd[N-2:0], w_qbit};
    assign w_last     = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dvd       <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_dbz       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_dvd   <= a;
                        r_div   <= b;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_dbz   <= (b == '0);
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (r_dbz) begin
                        // Zero divisor: a single busy cycle, then publish the fixed result.
                        r_dbz       <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= '1;
                        remainder   <= r_dvd;
                        div_by_zero <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_dvd <= w_quo_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= w_quo_next;
                            remainder   <= w_rem_next[N-1:0];
                            div_by_zero <= 1'b0;
                            r_state     <= DONE;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and exhaustive checks of seq_divider at N=4
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    seq_divider #(.N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for done; returns the number of edges after the accepting edge.
    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        while (!done && edges < 20) begin
            chk({tag, " busy_during"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_div(input logic [3:0] ta, input logic [3:0] tb_in, input logic [3:0] eq,
                           input logic [3:0] er, input logic ed, input int elat, input string tag);
        int edges;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_in;
        @(negedge clk);
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
        wait_done(tag, edges);
        chk({tag, " latency"}, edges, elat);
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " quotient"}, {28'd0, quotient}, {28'd0, eq});
        chk({tag, " remainder"}, {28'd0, remainder}, {28'd0, er});
        chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ed});
        @(negedge clk);
        chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, " quotient_hold"}, {28'd0, quotient}, {28'd0, eq});
    endtask

    initial begin
        int edges;
        vecs[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, dz: 1'b0, lat: 4};
        vecs[1] = '{a: 4'd3,  b: 4'd9,  q: 4'd0,  r: 4'd3, dz: 1'b0, lat: 4};
        vecs[2] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0, lat: 4};
        vecs[3] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, dz: 1'b1, lat: 1};
        vecs[4] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0, lat: 4};
        vecs[5] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0, lat: 4};
        vecs[6] = '{a: 4'd14, b: 4'd3,  q: 4'd4,  r: 4'd2, dz: 1'b0, lat: 4};

        rst   = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset quotient", {28'd0, quotient}, 32'd0);
        chk("reset remainder", {28'd0, remainder}, 32'd0);
        chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);

        // start held across reset release: ignored under reset, accepted on the first free edge
        start = 1'b1;
        a     = 4'd13;
        b     = 4'd4;
        @(negedge clk);
        chk("start_in_reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done("first_accept", edges);
        chk("first_accept latency", edges, 32'd4);
        chk("first_accept quotient", {28'd0, quotient}, 32'd3);
        chk("first_accept remainder", {28'd0, remainder}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat,
                    $sformatf("vec%0d", i));

        // start during RUN ignored, start in the DONE cycle accepted
        @(negedge clk);
        start = 1'b1;
        a     = 4'd13;
        b     = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd2;
        @(negedge clk);
        start = 1'b0;
        edges = 2;
        while (!done && edges < 20) begin
            chk("ignore busy_during", {31'd0, busy}, 32'd1);
            @(negedge clk);
            edges++;
        end
        chk("ignore latency", edges, 32'd4);
        chk("ignore quotient", {28'd0, quotient}, 32'd3);
        chk("ignore remainder", {28'd0, remainder}, 32'd1);
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("from_done", edges);
        chk("from_done latency", edges, 32'd4);
        chk("from_done quotient", {28'd0, quotient}, 32'd4);
        chk("from_done remainder", {28'd0, remainder}, 32'd1);
        chk("from_done div_by_zero", {31'd0, div_by_zero}, 32'd0);

        // divide-by-zero straight out of DONE
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done("dbz_from_done", edges);
        chk("dbz_from_done latency", edges, 32'd1);
        chk("dbz_from_done remainder", {28'd0, remainder}, 32'd5);
        chk("dbz_from_done div_by_zero", {31'd0, div_by_zero}, 32'd1);
        @(negedge clk);

        run_div(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 4, "pre_abort");

        // asynchronous reset in the middle of a run
        @(negedge clk);
        start = 1'b1;
        a     = 4'd13;
        b     = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort quotient", {28'd0, quotient}, 32'd0);
        chk("abort remainder", {28'd0, remainder}, 32'd0);
        chk("abort div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) edges++;
        end
        chk("abort no_done_or_busy", edges, 32'd0);
        run_div(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 4, "post_abort");

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 1; ib < 16; ib++)
                run_div(4'(ia), 4'(ib), 4'(ia / ib), 4'(ia % ib), 1'b0, 4,
                        $sformatf("sweep_%0d_%0d", ia, ib));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
